traffic_phase_scheduler: RTL and testbench

//  Sequences the two-road intersection through GreenA -> YellowA -> GreenB -> YellowB.

---
 rtl/traffic_phase_scheduler.sv | 145 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer: GA -> YA -> GB -> YB, with a BCD countdown,
// an early end of a green phase when its road is empty, and manual right-of-way requests.
// Latency: every output is registered and reflects inputs sampled at the previous edge.
// Backpressure: none; inputs are level signals sampled every cycle.
// Ports: CLK clock; R sync active-low reset; M manual mode; A/B manual requests;
//   A_Traffic/B_Traffic vehicles waiting; A_Light/B_Light greens; Yellow yellow phase;
//   A_Time_H/L, B_Time_H/L BCD displays; State phase code (0 GA, 1 YA, 2 GB, 3 YB).
module traffic_phase_scheduler #(
  parameter logic [7:0] GREEN_A_TIME = 8'h90,
  parameter logic [7:0] GREEN_B_TIME = 8'h30,
  parameter logic [7:0] YELLOW_TIME  = 8'h05,
  parameter int         MIN_GREEN    = 10,
  parameter int         EMPTY_CYCLES = 5
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       M,
  input  logic       A,
  input  logic       B,
  input  logic       A_Traffic,
  input  logic       B_Traffic,
  output logic       A_Light,
  output logic       B_Light,
  output logic       Yellow,
  output logic [3:0] A_Time_H,
  output logic [3:0] A_Time_L,
  output logic [3:0] B_Time_H,
  output logic [3:0] B_Time_L,
  output logic [1:0] State
);

  function automatic logic bcd_legal(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v != 8'h00);
  endfunction

  if (!bcd_legal(GREEN_A_TIME)) begin : g_bad_green_a
    $error("GREEN_A_TIME must be two-digit BCD in 01..99");
  end
  if (!bcd_legal(GREEN_B_TIME)) begin : g_bad_green_b
    $error("GREEN_B_TIME must be two-digit BCD in 01..99");
  end
  if (!bcd_legal(YELLOW_TIME)) begin : g_bad_yellow
    $error("YELLOW_TIME must be two-digit BCD in 01..99");
  end
  if (MIN_GREEN < 1 || MIN_GREEN > 99) begin : g_bad_min_green
    $error("MIN_GREEN must be in 1..99");
  end
  if (EMPTY_CYCLES < 1 || EMPTY_CYCLES > 15) begin : g_bad_empty_cycles
    $error("EMPTY_CYCLES must be in 1..15");
  end

  // elapsed holds completed green cycles, so "current cycle counted" means elapsed >= MIN_GREEN-1.
  localparam logic [6:0] MIN_LIM   = 7'(MIN_GREEN - 1);
  localparam logic [3:0] EMPTY_LIM = 4'(EMPTY_CYCLES);

  typedef enum logic [1:0] {GA = 2'd0, YA = 2'd1, GB = 2'd2, YB = 2'd3} phase_t;

  phase_t     phase, phase_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_dec;
  logic [3:0] empty, empty_nxt;
  logic [6:0] elapsed, elapsed_nxt;
  logic       green, qual, early_end, req_other;

  // Two-digit BCD decrement with tens borrow.
  always_comb begin
    cnt_dec = (cnt[3:0] == 4'd0) ? {cnt[7:4] - 4'd1, 4'd9} : {cnt[7:4], cnt[3:0] - 4'd1};
  end

  always_comb begin
    green     = (phase == GA) || (phase == GB);
    qual      = green && !M &&
                ((phase == GA) ? (!A_Traffic && B_Traffic) : (!B_Traffic && A_Traffic));
    empty_nxt = qual ? ((empty == EMPTY_LIM) ? empty : empty + 4'd1) : 4'd0;
    // empty_nxt includes the current cycle, so the run of qualifying cycles ends here.
    early_end = qual && (elapsed >= MIN_LIM) && (empty_nxt == EMPTY_LIM);
    req_other = M && ((phase == GA) ? (B && !A) : (A && !B));
    elapsed_nxt = (green && (elapsed != MIN_LIM)) ? elapsed + 7'd1 : elapsed;
    phase_nxt = phase;
    cnt_nxt   = cnt;

    case (phase)
      GA, GB: begin
        if (M ? req_other : (early_end || cnt == 8'h01)) begin
          phase_nxt = (phase == GA) ? YA : YB;
          cnt_nxt   = YELLOW_TIME;
        end else if (!M) begin
          cnt_nxt = cnt_dec;
        end
      end
      YA: begin
        if (cnt == 8'h01) begin
          phase_nxt = GB;
          cnt_nxt   = GREEN_B_TIME;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
      default: begin
        if (cnt == 8'h01) begin
          phase_nxt = GA;
          cnt_nxt   = GREEN_A_TIME;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end
    endcase

    // Every phase entry starts the early-end bookkeeping afresh.
    if (phase_nxt != phase) begin
      empty_nxt   = 4'd0;
      elapsed_nxt = 7'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      phase    <= GA;
      cnt      <= GREEN_A_TIME;
      empty    <= 4'd0;
      elapsed  <= 7'd0;
      A_Light  <= 1'b1;
      B_Light  <= 1'b0;
      Yellow   <= 1'b0;
      A_Time_H <= GREEN_A_TIME[7:4];
      A_Time_L <= GREEN_A_TIME[3:0];
      B_Time_H <= 4'd0;
      B_Time_L <= 4'd0;
      State    <= 2'd0;
    end else begin
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      empty    <= empty_nxt;
      elapsed  <= elapsed_nxt;
      A_Light  <= (phase_nxt == GA);
      B_Light  <= (phase_nxt == GB);
      Yellow   <= (phase_nxt == YA) || (phase_nxt == YB);
      A_Time_H <= (phase_nxt == GA || phase_nxt == YA) ? cnt_nxt[7:4] : 4'd0;
      A_Time_L <= (phase_nxt == GA || phase_nxt == YA) ? cnt_nxt[3:0] : 4'd0;
      B_Time_H <= (phase_nxt == GB || phase_nxt == YB) ? cnt_nxt[7:4] : 4'd0;
      B_Time_L <= (phase_nxt == GB || phase_nxt == YB) ? cnt_nxt[3:0] : 4'd0;
      State    <= phase_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  logic       CLK = 1'b0;
  logic       R, M, A, B, A_Traffic, B_Traffic;
  logic       A_Light, B_Light, Yellow;
  logic [3:0] A_Time_H, A_Time_L, B_Time_H, B_Time_L;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;

  traffic_phase_scheduler dut (
    .CLK(CLK), .R(R), .M(M), .A(A), .B(B),
    .A_Traffic(A_Traffic), .B_Traffic(B_Traffic),
    .A_Light(A_Light), .B_Light(B_Light), .Yellow(Yellow),
    .A_Time_H(A_Time_H), .A_Time_L(A_Time_L),
    .B_Time_H(B_Time_H), .B_Time_L(B_Time_L),
    .State(State)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase index, remaining count as a plain integer,
  // green cycles shown so far and the length of the current qualifying run.
  localparam int MIN_G = 10;
  localparam int EMPTY_N = 5;
  int phase_len [4] = '{90, 5, 30, 5};
  int m_phase, m_cnt, m_shown, m_run;

  task automatic enter_phase(input int p);
    m_phase = p;
    m_cnt   = phase_len[p];
    m_shown = 0;
    m_run   = 0;
  endtask

  task automatic model_edge();
    bit q;
    if (!R) begin
      enter_phase(0);
    end else if (m_phase == 0 || m_phase == 2) begin
      m_shown++;
      if (M) begin
        m_run = 0;
        if ((m_phase == 0 && B && !A) || (m_phase == 2 && A && !B)) enter_phase(m_phase + 1);
      end else begin
        q = (m_phase == 0) ? (!A_Traffic && B_Traffic) : (!B_Traffic && A_Traffic);
        m_run = q ? m_run + 1 : 0;
        if ((m_shown >= MIN_G && m_run >= EMPTY_N) || m_cnt == 1) enter_phase(m_phase + 1);
        else m_cnt--;
      end
    end else begin
      if (m_cnt == 1) enter_phase((m_phase + 1) % 4);
      else m_cnt--;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int at, bt;
    at = (m_phase < 2) ? m_cnt : 0;
    bt = (m_phase >= 2) ? m_cnt : 0;
    chk("state", State, m_phase);
    chk("a_light", A_Light, m_phase == 0);
    chk("b_light", B_Light, m_phase == 2);
    chk("yellow", Yellow, m_phase == 1 || m_phase == 3);
    chk("a_time_h", A_Time_H, at / 10);
    chk("a_time_l", A_Time_L, at % 10);
    chk("b_time_h", B_Time_H, bt / 10);
    chk("b_time_l", B_Time_L, bt % 10);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge CLK);
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    R = 1'b0;
    step(1);
    R = 1'b1;
  endtask

  initial begin
    R = 1'b0; M = 1'b0; A = 1'b0; B = 1'b0; A_Traffic = 1'b1; B_Traffic = 1'b1;
    enter_phase(0);

    // Reset state.
    do_reset();
    chk("rst_state", State, 0);
    chk("rst_a_light", A_Light, 1);
    chk("rst_a_time_h", A_Time_H, 9);

    // Full automatic cycle with BCD borrows.
    step(1);
    chk("borrow_89_h", A_Time_H, 8);
    chk("borrow_89_l", A_Time_L, 9);
    step(80);
    chk("borrow_09_h", A_Time_H, 0);
    chk("borrow_09_l", A_Time_L, 9);
    chk("ga_b_time", {B_Time_H, B_Time_L}, 0);
    step(49);
    chk("cycle130_state", State, 0);
    chk("cycle130_a_h", A_Time_H, 9);
    chk("cycle130_a_l", A_Time_L, 0);

    // Early end after the minimum green.
    A_Traffic = 1'b0; B_Traffic = 1'b1;
    do_reset();
    step(9);
    chk("early_not_yet", State, 0);
    step(1);
    chk("early_ya", State, 1);
    chk("early_ya_l", A_Time_L, 5);

    // Qualifying run broken at count 84 -> ends after 79.
    do_reset();
    step(6);
    A_Traffic = 1'b1;
    step(1);
    A_Traffic = 1'b0;
    step(4);
    chk("broken_run_ga", State, 0);
    step(1);
    chk("broken_run_ya", State, 1);

    // Manual mode.
    A_Traffic = 1'b1;
    do_reset();
    step(20);
    chk("man_start_70", A_Time_H, 7);
    M = 1'b1; B = 1'b1;
    step(1);
    chk("man_ya", State, 1);
    B = 1'b0;
    step(5);
    chk("man_gb", State, 2);
    step(20);
    chk("man_gb_hold_h", B_Time_H, 3);
    chk("man_gb_hold_l", B_Time_L, 0);
    A = 1'b1; B = 1'b1;
    step(3);
    chk("man_both_ignored", State, 2);
    B = 1'b0;
    step(1);
    chk("man_yb", State, 3);
    A = 1'b0;
    step(5);
    chk("man_ga", State, 0);
    step(10);
    chk("man_ga_hold", A_Time_L, 0);
    M = 1'b0;
    step(1);
    chk("resume_89_h", A_Time_H, 8);
    chk("resume_89_l", A_Time_L, 9);
    step(5);

    // Reset during YB at 03.
    do_reset();
    step(127);
    chk("yb_at_03", B_Time_L, 3);
    do_reset();
    chk("rst_yb_state", State, 0);
    chk("rst_yb_yellow", Yellow, 0);

    // Early-end progress discarded by reset.
    A_Traffic = 1'b0;
    step(8);
    do_reset();
    step(9);
    chk("discard_ga", State, 0);
    step(1);
    chk("discard_ya", State, 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      R = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) M = ~M;
      A = ($urandom_range(0, 9) == 0);
      B = ($urandom_range(0, 9) == 0);
      A_Traffic = $urandom_range(0, 3) != 0;
      B_Traffic = $urandom_range(0, 1) != 0;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
